// File: rtl/obstacle_sequencer.sv
// obstacle_sequencer: frame-driven scheduler for the shared obstacle mux.
// It alternates GAP periods (no obstacle) and RUN periods (one obstacle
// selected). Periods are counted in frames, using the rising edges of vsync.
// Optional feature macro: OBSTACLE_SEQ_LOOP_EN. When defined, the round loops
// endlessly and never declares victory.
module obstacle_sequencer #(
  parameter int NUM_OBSTACLES = 2,
  parameter int RUN_FRAMES    = 600,
  parameter int GAP_FRAMES    = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        play_selected,
  input  logic        game_over,
  output logic [3:0]  obstacle_select,
  output logic        obstacle_active,
  output logic [11:0] frames_left,
  output logic [3:0]  round_idx,
  output logic        victory
);

  localparam logic [11:0] GAP_LOAD = 12'(GAP_FRAMES - 1);
  localparam logic [11:0] RUN_LOAD = 12'(RUN_FRAMES - 1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_OBSTACLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        vs_d;
  logic        tick;
  logic        abort;
  logic [11:0] frames_nxt;
  logic [3:0]  idx_nxt;
  logic [3:0]  sel_nxt;
  logic        active_nxt;
  logic        victory_nxt;

  assign tick  = vsync_in & ~vs_d;
  // Leaving the game screen or dying ends the round.
  assign abort = game_over | ~play_selected;

  // State, counters, edge detector and registered outputs.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      vs_d            <= 1'b0;
      frames_left     <= '0;
      round_idx       <= '0;
      obstacle_select <= '0;
      obstacle_active <= 1'b0;
      victory         <= 1'b0;
    end else begin
      state           <= state_nxt;
      vs_d            <= vsync_in;
      frames_left     <= frames_nxt;
      round_idx       <= idx_nxt;
      obstacle_select <= sel_nxt;
      obstacle_active <= active_nxt;
      victory         <= victory_nxt;
    end
  end

  // Next state and counter values. An abort takes priority over a tick that arrives in the same cycle.
  always_comb begin
    state_nxt  = state;
    frames_nxt = frames_left;
    idx_nxt    = round_idx;
    unique case (state)
      S_IDLE: begin
        frames_nxt = '0;
        idx_nxt    = '0;
        if (play_selected && !game_over) begin
          state_nxt  = S_GAP;
          frames_nxt = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          frames_nxt = '0;
          idx_nxt    = '0;
        end else if (tick) begin
          if (frames_left != '0) begin
            frames_nxt = frames_left - 12'd1;
          end else begin
            state_nxt  = S_RUN;
            frames_nxt = RUN_LOAD;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          frames_nxt = '0;
          idx_nxt    = '0;
        end else if (tick) begin
          if (frames_left != '0) begin
            frames_nxt = frames_left - 12'd1;
          end else if (round_idx < LAST_IDX) begin
            state_nxt  = S_GAP;
            frames_nxt = GAP_LOAD;
            idx_nxt    = round_idx + 4'd1;
          end else begin
`ifdef OBSTACLE_SEQ_LOOP_EN
            state_nxt  = S_GAP;
            frames_nxt = GAP_LOAD;
            idx_nxt    = '0;
`else
            state_nxt  = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_nxt  = S_IDLE;
          frames_nxt = '0;
          idx_nxt    = '0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        frames_nxt = '0;
        idx_nxt    = '0;
      end
    endcase
  end

  // Output values for the coming state, so that every output leaves a flop.
  always_comb begin
    sel_nxt     = '0;
    active_nxt  = 1'b0;
    victory_nxt = 1'b0;
    if (state_nxt == S_RUN) begin
      sel_nxt    = idx_nxt;
      active_nxt = 1'b1;
    end
    if (state_nxt == S_DONE) begin
      victory_nxt = 1'b1;
    end
  end

endmodule
